uart_tx_arbiter: RTL and testbench

//  Shares one UART transmitter between N byte-stream requesters using round-robin arbitration.

---
 rtl/uart_tx_arbiter.sv | 233 +++++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmitter between N byte-stream requesters.
//   Requesters are served in round-robin order. A requester keeps the grant
//   for a whole packet, which ends with the byte flagged last=1.
//   Each accepted byte is registered onto o_tx_data and launched with a
//   one-cycle o_tx_start pulse. The arbiter then tracks the transmitter's
//   busy rise and fall before it accepts another byte.
//   A missing busy rise, or a locked requester stalling mid-packet, raises
//   a one-cycle o_error and forces release of the grant.
//
// Ports
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_req_valid[N]   per-requester byte valid
//   i_req_data[N*W]  requester k drives bits [k*W +: W]
//   i_req_last[N]    last byte of packet, sampled with the data
//   o_req_ready[N]   one-hot ready; a byte moves on valid & ready
//   o_tx_data[W]     registered byte to transmitter
//   o_tx_start       one-cycle start pulse
//   i_tx_busy        transmitter busy, high for the whole frame
//   o_grant[N]       one-hot current owner, 0 when unowned
//   o_busy           high whenever the FSM is not idle
//   o_error          one-cycle pulse on start or hold timeout
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | no owner; round-robin pick from the pointer, accept one byte
// START     | pulse o_tx_start, arm the start timeout
// WAIT_BUSY | wait for transmitter busy to rise, or time out
// WAIT_DONE | wait for busy to fall; release on last, otherwise hold
// HOLD      | owner keeps the grant; wait for its next byte, or time out
module uart_tx_arbiter #(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int START_TO = 16,
  parameter int HOLD_TO  = 64
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic [N-1:0]   i_req_valid,
  input  logic [N*W-1:0] i_req_data,
  input  logic [N-1:0]   i_req_last,
  output logic [N-1:0]   o_req_ready,
  output logic [W-1:0]   o_tx_data,
  output logic           o_tx_start,
  input  logic           i_tx_busy,
  output logic [N-1:0]   o_grant,
  output logic           o_busy,
  output logic           o_error
);

  localparam int IW   = (N > 1) ? $clog2(N) : 1;
  localparam int TMAX = (START_TO > HOLD_TO) ? START_TO : HOLD_TO;
  localparam int TW   = $clog2(TMAX + 1);
  // Down-counters load TO-1 so that terminal count zero lands on the TO-th cycle.
  localparam logic [TW-1:0] START_LOAD = TW'(START_TO - 1);
  localparam logic [TW-1:0] HOLD_LOAD  = TW'(HOLD_TO - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_HOLD
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_arm;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_owner;
  logic [TW-1:0]   r_timer;
  logic            r_lock_end;
  logic [W-1:0]    r_tx_data;
  logic [N-1:0]    r_grant;

  logic            w_hi_found;
  logic            w_lo_found;
  logic [IW-1:0]   w_hi_idx;
  logic [IW-1:0]   w_lo_idx;
  logic            w_pick_found;
  logic [IW-1:0]   w_pick_idx;
  logic [IW-1:0]   w_sel_idx;
  logic [W-1:0]    w_sel_data;
  logic            w_sel_last;
  logic            w_sel_valid;
  logic [N-1:0]    w_ready;
  logic            w_start;
  logic            w_error;
  logic            w_load;
  logic            w_release;
  logic            w_timer_start;
  logic            w_timer_hold;

  function automatic logic [N-1:0] onehot(input logic [IW-1:0] idx);
    return N'(1) << idx;
  endfunction

  // Round-robin search split in two passes: indices at/above the pointer win
  // over the wrapped ones below it; the descending loop leaves the lowest index.
  always_comb begin
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_req_valid[k]) begin
        if (k >= int'(r_ptr)) begin
          w_hi_found = 1'b1;
          w_hi_idx   = IW'(k);
        end else begin
          w_lo_found = 1'b1;
          w_lo_idx   = IW'(k);
        end
      end
    end
    w_pick_found = w_hi_found | w_lo_found;
    w_pick_idx   = w_hi_found ? w_hi_idx : w_lo_idx;
  end

  // In HOLD only the locked owner is eligible; elsewhere the fresh pick is used.
  always_comb begin
    w_sel_idx   = (r_state == S_HOLD) ? r_owner : w_pick_idx;
    w_sel_data  = '0;
    w_sel_last  = 1'b0;
    w_sel_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (int'(w_sel_idx) == k) begin
        w_sel_data  = i_req_data[k*W +: W];
        w_sel_last  = i_req_last[k];
        w_sel_valid = i_req_valid[k];
      end
    end
  end

  always_comb begin
    w_next        = r_state;
    w_ready       = '0;
    w_start       = 1'b0;
    w_error       = 1'b0;
    w_load        = 1'b0;
    w_release     = 1'b0;
    w_timer_start = 1'b0;
    w_timer_hold  = 1'b0;
    case (r_state)
      S_IDLE: begin
        // r_arm holds ready low until the first clock after reset release.
        if (r_arm && w_pick_found) begin
          w_ready = onehot(w_pick_idx);
          w_load  = 1'b1;
          w_next  = S_START;
        end
      end
      S_START: begin
        w_start       = 1'b1;
        w_timer_start = 1'b1;
        w_next        = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (i_tx_busy) begin
          w_next = S_WAIT_DONE;
        end else if (r_timer == '0) begin
          w_error   = 1'b1;
          w_release = 1'b1;
          w_next    = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        if (!i_tx_busy) begin
          if (r_lock_end) begin
            w_release = 1'b1;
            w_next    = S_IDLE;
          end else begin
            w_timer_hold = 1'b1;
            w_next       = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (w_sel_valid) begin
          w_ready = onehot(r_owner);
          w_load  = 1'b1;
          w_next  = S_START;
        end else if (r_timer == '0) begin
          w_error   = 1'b1;
          w_release = 1'b1;
          w_next    = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_arm      <= 1'b0;
      r_ptr      <= '0;
      r_owner    <= '0;
      r_timer    <= '0;
      r_lock_end <= 1'b0;
      r_tx_data  <= '0;
      r_grant    <= '0;
    end else begin
      r_state <= w_next;
      r_arm   <= 1'b1;
      if (w_load) begin
        r_tx_data  <= w_sel_data;
        r_lock_end <= w_sel_last;
        r_owner    <= w_sel_idx;
        r_grant    <= onehot(w_sel_idx);
      end
      if (w_release) begin
        r_grant <= '0;
        r_ptr   <= (r_owner == IW'(N - 1)) ? '0 : r_owner + IW'(1);
      end
      if (w_timer_start) begin
        r_timer <= START_LOAD;
      end else if (w_timer_hold) begin
        r_timer <= HOLD_LOAD;
      end else if (((r_state == S_WAIT_BUSY) || (r_state == S_HOLD)) && (r_timer != '0)) begin
        r_timer <= r_timer - 1'b1;
      end
    end
  end

  assign o_req_ready = w_ready;
  assign o_tx_start  = w_start;
  assign o_error     = w_error;
  assign o_busy      = (r_state != S_IDLE);
  assign o_grant     = r_grant;
  assign o_tx_data   = r_tx_data;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester sources and a transmitter
// busy model are advanced one clock at a time by the cycle task; outputs are
// sampled on the falling edge and checked against hand-derived expectations.
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   tx_data;
  logic           tx_start;
  logic           tx_busy;
  logic [N-1:0]   grant;
  logic           busy;
  logic           error;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N(N), .W(W), .START_TO(16), .HOLD_TO(64)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .i_req_data  (req_data),
    .i_req_last  (req_last),
    .o_req_ready (req_ready),
    .o_tx_data   (tx_data),
    .o_tx_start  (tx_start),
    .i_tx_busy   (tx_busy),
    .o_grant     (grant),
    .o_busy      (busy),
    .o_error     (error)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int snap_cyc = 0;
  logic snap_busy;
  logic [N-1:0] snap_grant;
  int multi_cnt = 0;

  int src_left[N];
  logic src_end[N];
  logic src_last_all[N];
  logic [W-1:0] src_byte[N];

  bit tx_en = 1'b1;
  int tx_len = 10;
  bit tx_pend = 1'b0;
  int tx_cnt = 0;

  int xfer_who[$];
  int xfer_cyc[$];
  logic [N-1:0] xfer_grant[$];
  int start_cyc[$];
  logic [W-1:0] start_data[$];
  logic [N-1:0] start_grant[$];
  int err_cyc[$];
  int fall_cyc[$];
  int ready_cnt[N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_src();
    for (int k = 0; k < N; k++) begin
      req_valid[k]         = (src_left[k] > 0);
      req_data[k*W +: W]   = src_byte[k];
      req_last[k]          = (src_left[k] == 1) ? src_end[k] : src_last_all[k];
    end
  endtask

  task automatic clear_logs();
    xfer_who.delete();
    xfer_cyc.delete();
    xfer_grant.delete();
    start_cyc.delete();
    start_data.delete();
    start_grant.delete();
    err_cyc.delete();
    fall_cyc.delete();
    for (int k = 0; k < N; k++) ready_cnt[k] = 0;
  endtask

  task automatic cycle();
    @(negedge clk);
    snap_cyc   = cyc;
    snap_busy  = busy;
    snap_grant = grant;
    if ($countones(req_ready) > 1) multi_cnt++;
    for (int k = 0; k < N; k++) begin
      if (req_ready[k]) ready_cnt[k]++;
      if (req_valid[k] && req_ready[k]) begin
        xfer_who.push_back(k);
        xfer_cyc.push_back(cyc);
        xfer_grant.push_back(grant);
        src_left[k]--;
        src_byte[k]++;
      end
    end
    if (tx_start) begin
      start_cyc.push_back(cyc);
      start_data.push_back(tx_data);
      start_grant.push_back(grant);
      if (tx_en) tx_pend = 1'b1;
    end
    if (error) err_cyc.push_back(cyc);
    @(posedge clk);
    #1;
    cyc++;
    if (tx_pend) begin
      tx_busy = 1'b1;
      tx_cnt  = tx_len;
      tx_pend = 1'b0;
    end else if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) begin
        tx_busy = 1'b0;
        fall_cyc.push_back(cyc);
      end
    end
    drive_src();
  endtask

  task automatic run_until(input int n, input int bound, input string tag);
    bit done = 1'b0;
    for (int i = 0; i < bound && !done; i++) begin
      cycle();
      if (xfer_who.size() >= n && !snap_busy && tx_cnt == 0 && !tx_pend &&
          xfer_cyc[xfer_cyc.size()-1] < snap_cyc)
        done = 1'b1;
    end
    check({tag, " finished"}, 32'(done), 32'd1);
  endtask

  task automatic wait_xfers(input int n, input int bound, input string tag);
    for (int i = 0; i < bound && xfer_who.size() < n; i++) cycle();
    check({tag, " transfer seen"}, 32'(xfer_who.size() >= n), 32'd1);
  endtask

  task automatic check_order(input string tag, input int exp[$]);
    check({tag, " count"}, 32'(xfer_who.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < xfer_who.size(); i++)
      check($sformatf("%s order[%0d]", tag, i), 32'(xfer_who[i]), 32'(exp[i]));
  endtask

  initial begin
    int n_k;
    rst_n   = 1'b0;
    tx_busy = 1'b0;
    for (int k = 0; k < N; k++) begin
      src_left[k]     = 0;
      src_end[k]      = 1'b1;
      src_last_all[k] = 1'b0;
      src_byte[k]     = '0;
      ready_cnt[k]    = 0;
    end
    drive_src();
    #3;
    check("reset grant",   32'(grant), 32'd0);
    check("reset busy",    32'(busy), 32'd0);
    check("reset start",   32'(tx_start), 32'd0);
    check("reset error",   32'(error), 32'd0);
    check("reset tx_data", 32'(tx_data), 32'd0);
    check("reset ready",   32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Round-robin: all four offer two single-byte packets.
    for (int k = 0; k < N; k++) begin
      src_left[k]     = 2;
      src_last_all[k] = 1'b1;
      src_byte[k]     = 8'(k * 16);
    end
    drive_src();
    run_until(8, 400, "rr");
    check_order("rr", '{0, 1, 2, 3, 0, 1, 2, 3});
    for (int k = 0; k < N; k++) begin
      n_k = 0;
      foreach (xfer_who[i]) if (xfer_who[i] == k) n_k++;
      check($sformatf("rr bytes req%0d", k), 32'(n_k), 32'd2);
    end
    for (int k = 0; k < N; k++) src_last_all[k] = 1'b0;

    // Single byte 0x55 from req0.
    clear_logs();
    src_left[0] = 1;
    src_end[0]  = 1'b1;
    src_byte[0] = 8'h55;
    drive_src();
    run_until(1, 100, "single");
    check_order("single", '{0});
    check("single ready0 pulses", 32'(ready_cnt[0]), 32'd1);
    check("single start count", 32'(start_cyc.size()), 32'd1);
    if (start_cyc.size() == 1 && xfer_cyc.size() == 1) begin
      check("single start latency", 32'(start_cyc[0] - xfer_cyc[0]), 32'd1);
      check("single tx_data", 32'(start_data[0]), 32'h55);
      check("single grant", 32'(start_grant[0]), 32'b0001);
    end
    check("single grant idle", 32'(snap_grant), 32'd0);

    // Lock: req1 sends three bytes; req2 and req0 wait. Pointer is 1 here.
    clear_logs();
    src_left[1] = 3;  src_end[1] = 1'b1;
    src_left[2] = 1;  src_end[2] = 1'b1;
    src_left[0] = 1;  src_end[0] = 1'b1;
    drive_src();
    run_until(5, 400, "lock");
    check_order("lock", '{1, 1, 1, 2, 0});
    check("lock req2 ready pulses", 32'(ready_cnt[2]), 32'd1);
    if (xfer_cyc.size() >= 4 && fall_cyc.size() >= 3)
      check("lock req2 after 3rd frame", 32'(xfer_cyc[3] - fall_cyc[2]), 32'd1);

    // Start timeout: transmitter never raises busy. Pointer is 1 here.
    clear_logs();
    tx_en = 1'b0;
    src_left[1] = 1;
    src_left[2] = 1;
    drive_src();
    run_until(2, 200, "start_to");
    check_order("start_to", '{1, 2});
    check("start_to errors", 32'(err_cyc.size()), 32'd2);
    if (err_cyc.size() >= 1 && start_cyc.size() >= 1)
      check("start_to delay", 32'(err_cyc[0] - start_cyc[0]), 32'd16);
    if (err_cyc.size() >= 1 && xfer_cyc.size() >= 2) begin
      check("start_to next served", 32'(xfer_cyc[1] - err_cyc[0]), 32'd1);
      check("start_to grant cleared", 32'(xfer_grant[1]), 32'd0);
    end
    tx_en = 1'b1;

    // Hold timeout: req0 sends last=0 then goes quiet; req3 arrives meanwhile.
    clear_logs();
    src_left[0] = 1;
    src_end[0]  = 1'b0;
    drive_src();
    wait_xfers(1, 50, "hold_to first");
    src_left[3] = 1;
    src_end[3]  = 1'b1;
    run_until(2, 300, "hold_to");
    check_order("hold_to", '{0, 3});
    check("hold_to errors", 32'(err_cyc.size()), 32'd1);
    if (err_cyc.size() >= 1 && fall_cyc.size() >= 1)
      check("hold_to delay", 32'(err_cyc[0] - fall_cyc[0]), 32'd64);
    if (err_cyc.size() >= 1 && xfer_cyc.size() >= 2)
      check("hold_to req3 next", 32'(xfer_cyc[1] - err_cyc[0]), 32'd1);
    check("hold_to req3 ready pulses", 32'(ready_cnt[3]), 32'd1);
    src_end[0] = 1'b1;

    // Reset during WAIT_DONE of a req2 frame, with req0 and req3 pending.
    clear_logs();
    src_left[2] = 1;
    drive_src();
    wait_xfers(1, 50, "reset frame");
    for (int i = 0; i < 40 && tx_cnt != 5; i++) cycle();
    check("reset mid-frame reached", 32'(tx_cnt), 32'd5);
    src_left[0] = 1;
    src_left[3] = 1;
    cycle();
    rst_n = 1'b0;
    #1;
    check("abort grant",   32'(grant), 32'd0);
    check("abort busy",    32'(busy), 32'd0);
    check("abort start",   32'(tx_start), 32'd0);
    check("abort error",   32'(error), 32'd0);
    check("abort tx_data", 32'(tx_data), 32'd0);
    check("abort ready",   32'(req_ready), 32'd0);
    repeat (3) cycle();
    rst_n = 1'b1;
    clear_logs();
    run_until(2, 200, "after reset");
    check_order("after reset", '{0, 3});

    check("ready one-hot", 32'(multi_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
